thread_lsu: RTL and testbench
=============================

# thread_lsu

Per-thread load/store unit. It sits directly downstream of the thread register file and consumes its `rs` (address) and `rt` (store data) outputs for LDR/STR instructions. It runs one data-memory transaction per request over a valid/ready memory channel and returns loaded data on `lsu_out`, which the writeback path feeds to `reg_write_data`. One instance exists per thread per core.

## Interface
- `DATA_BITS`, default 8: register and memory data width.
- `ADDR_BITS`, default 8: data-memory address width. Must be ≤ `DATA_BITS`.
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-low (asserted at 0).
- `enable` input, 1 bit: thread is active in the current block. An inactive thread accepts no requests.
- `req_valid` input, 1 bit: an LDR/STR is presented.
- `req_ready` output, 1 bit: unit can accept a request.
- `req_write` input, 1 bit: 1 = STR, 0 = LDR. Sampled at acceptance.
- `rs` input, `DATA_BITS`: address operand from the register file.
- `rt` input, `DATA_BITS`: store data from the register file.
- `mem_read_valid` output, 1 bit: read request.
- `mem_read_address` output, `ADDR_BITS`: read address.
- `mem_read_ready` input, 1 bit: memory returns read data this cycle.
- `mem_read_data` input, `DATA_BITS`: read data, valid when `mem_read_ready` is 1.
- `mem_write_valid` output, 1 bit: write request.
- `mem_write_address` output, `ADDR_BITS`: write address.
- `mem_write_data` output, `DATA_BITS`: write data.
- `mem_write_ready` input, 1 bit: memory accepts the write this cycle.
- `lsu_out` output, `DATA_BITS`: last loaded value. Held until the next load completes.
- `lsu_done` output, 1 bit: one-cycle completion pulse for both loads and stores.
- `busy` output, 1 bit: a transaction is in flight (any state other than IDLE).

## Operation
- FSM states:
  - IDLE: `req_ready` = `enable`. On `req_valid && enable`, capture `rs[ADDR_BITS-1:0]` and `rt`, then go to RD_REQ (LDR) or WR_REQ (STR).
  - RD_REQ: `mem_read_valid` = 1 and `mem_read_address` = the captured address. On `mem_read_ready`, register `mem_read_data` into `lsu_out` and go to DONE.
  - WR_REQ: `mem_write_valid` = 1, with the captured address and data on the write ports. On `mem_write_ready`, go to DONE.
  - DONE: `lsu_done` = 1 for exactly one cycle, then IDLE unconditionally.
- Memory valids are decoded from the state register only. Address and data outputs come from capture registers and stay stable for the whole request.
- Memory may hold ready low for any number of cycles. The unit waits indefinitely; there is no timeout.
- `enable` falling while not IDLE does not abort the transaction. It completes, and `lsu_done` still pulses.
- `req_valid` outside IDLE is ignored, because `req_ready` is 0.
- Stores leave `lsu_out` unchanged.
- Reset values (while `reset` = 0):
  - state = IDLE.
  - All outputs = 0, including `lsu_out`, the memory valids, addresses, data, and `req_ready`.
- Reset is asynchronous. Asserting it mid-transaction drops `mem_*_valid` immediately, with no completion pulse.

## Timing
- Cycle 0: request accepted at the posedge where `req_valid && req_ready`.
- Cycle 1: state is RD_REQ or WR_REQ and the memory valid is high.
- If memory ready is 1 in cycle 1, cycle 2 is DONE (`lsu_done` = 1, `lsu_out` updated) and cycle 3 is IDLE with `req_ready` back to 1.
- Minimum latency is 2 cycles from acceptance to `lsu_done`, which gives at most one request per 3 cycles.
- Each ready cycle that memory stalls adds exactly one cycle to latency.
- `lsu_out` changes only on the posedge that enters DONE from RD_REQ.

## Structure
- Shared package `gpu_pkg`:
  - `lsu_state_t` enum: IDLE, RD_REQ, WR_REQ, DONE. 2-bit encoding.
  - Default `DATA_BITS`/`ADDR_BITS` localparams shared with the register file.
- No sub-module: the block is one FSM plus capture registers.

## Test plan
- **LDR, zero wait:** `enable` = 1, `rs` = 0x2A, `req_write` = 0, memory ready in the same cycle with data 0x5C → `mem_read_address` = 0x2A in cycle 1; `lsu_done` and `lsu_out` = 0x5C in cycle 2; `req_ready` = 1 in cycle 3.
- **STR, 3-cycle stall:** `rs` = 0x10, `rt` = 0xA5, `mem_write_ready` asserted on the 4th valid cycle → valid/address/data stable for 4 cycles; `lsu_done` one cycle later; `lsu_out` unchanged.
- **enable = 0 in IDLE:** `req_valid` = 1 → `req_ready` = 0, no memory valid, state stays IDLE.
- **enable drop mid-load:** `enable` falls in RD_REQ, memory answers 0x77 two cycles later → `lsu_done` pulses and `lsu_out` = 0x77.
- **Reset mid-write:** `reset` driven to 0 during WR_REQ → `mem_write_valid` goes to 0 in the same cycle, without waiting for an edge; after release, state is IDLE, `lsu_out` = 0, no `lsu_done`.
- **Back-to-back:** `req_valid` held high for an LDR followed by an STR → the second request is accepted only in the IDLE cycle after DONE; no request is lost or duplicated.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and default widths for the per-thread datapath
//
// Purpose: types shared by the thread register file and the thread load/store unit.
//   lsu_state_t       : load/store unit FSM state, 2-bit encoding
//   GPU_DATA_BITS     : default register / memory data width
//   GPU_ADDR_BITS     : default data-memory address width (never wider than data)
package gpu_pkg;

   localparam int GPU_DATA_BITS = 8;
   localparam int GPU_ADDR_BITS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_REQ = 2'd1,
      WR_REQ = 2'd2,
      DONE   = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// rtl/thread_lsu.sv - per-thread load/store unit, one memory transaction per request
//
// Purpose: accepts an LDR/STR from the register file (rs = address, rt = store data),
// runs a single valid/ready transaction on the data-memory channel and returns the
// loaded value on lsu_out with a one-cycle lsu_done pulse.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   enable                     : thread active; gates request acceptance only
//   req_valid/req_ready        : request handshake; req_write selects STR (1) or LDR (0)
//   rs, rt                     : address operand and store data
//   mem_read_*                 : read channel (valid/address out, ready/data in)
//   mem_write_*                : write channel (valid/address/data out, ready in)
//   lsu_out                    : last loaded value, held across stores
//   lsu_done                   : one-cycle completion pulse for loads and stores
//   busy                       : transaction in flight
module thread_lsu
   import gpu_pkg::*;
#(
   parameter int DATA_BITS = GPU_DATA_BITS,
   parameter int ADDR_BITS = GPU_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_done,
   output logic                 busy
);

   lsu_state_t           state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [DATA_BITS-1:0] out_q, out_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (req_valid && enable) begin
               addr_d  = rs[ADDR_BITS-1:0];
               data_d  = rt;
               state_d = req_write ? WR_REQ : RD_REQ;
            end
         end
         RD_REQ: begin
            if (mem_read_ready) begin
               out_d   = mem_read_data;
               state_d = DONE;
            end
         end
         WR_REQ: begin
            if (mem_write_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         out_q   <= out_d;
      end
   end

   // State is already IDLE during reset, so req_ready is also gated by reset
   // itself to keep it low while reset is held with enable high.
   assign req_ready         = reset && enable && (state_q == IDLE);
   assign mem_read_valid    = (state_q == RD_REQ);
   assign mem_write_valid   = (state_q == WR_REQ);
   assign mem_read_address  = addr_q;
   assign mem_write_address = addr_q;
   assign mem_write_data    = data_q;
   assign lsu_out           = out_q;
   assign lsu_done          = (state_q == DONE);
   assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_thread_lsu.sv
// tb/tb_thread_lsu.sv - scoreboard bench for thread_lsu
module tb_thread_lsu;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] rs;
   logic [7:0] rt;
   logic       mem_read_valid;
   logic [7:0] mem_read_address;
   logic       mem_read_ready;
   logic [7:0] mem_read_data;
   logic       mem_write_valid;
   logic [7:0] mem_write_address;
   logic [7:0] mem_write_data;
   logic       mem_write_ready;
   logic [7:0] lsu_out;
   logic       lsu_done;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   logic [7:0] exp_q[$];

   thread_lsu #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .rs                (rs),
      .rt                (rt),
      .mem_read_valid    (mem_read_valid),
      .mem_read_address  (mem_read_address),
      .mem_read_ready    (mem_read_ready),
      .mem_read_data     (mem_read_data),
      .mem_write_valid   (mem_write_valid),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_ready   (mem_write_ready),
      .lsu_out           (lsu_out),
      .lsu_done          (lsu_done),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (lsu_done === 1'b1) begin
         n_done++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: got lsu_out 0x%0h expected no completion", lsu_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (lsu_out !== e) begin
               n_fail++;
               $display("FAIL sb_lsu_out: got 0x%0h expected 0x%0h", lsu_out, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no end of test expected end before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; enable = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      rs = 8'h00; rt = 8'h00;
      mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;

      // Reset state
      sample();
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_valids", {mem_read_valid, mem_write_valid}, 0);
      check("rst_lsu_out", lsu_out, 0);
      check("rst_addr_data", {mem_read_address, mem_write_address, mem_write_data}, 0);
      check("rst_done_busy", {lsu_done, busy}, 0);
      next_cycle();
      reset = 1'b1;

      // LDR, zero wait
      req_valid = 1'b1; req_write = 1'b0; rs = 8'h2A;
      exp_q.push_back(8'h5C);
      sample();
      check("ldr_req_ready_c0", req_ready, 1);
      next_cycle();
      req_valid = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h5C;
      sample();
      check("ldr_rd_valid_c1", mem_read_valid, 1);
      check("ldr_rd_addr_c1", mem_read_address, 8'h2A);
      check("ldr_done_c1", lsu_done, 0);
      next_cycle();
      mem_read_ready = 1'b0; mem_read_data = 8'h00;
      sample();
      check("ldr_done_c2", lsu_done, 1);
      check("ldr_out_c2", lsu_out, 8'h5C);
      check("ldr_rd_valid_c2", mem_read_valid, 0);
      next_cycle();
      sample();
      check("ldr_req_ready_c3", req_ready, 1);
      check("ldr_done_c3", lsu_done, 0);

      // STR with 3 stall cycles
      req_valid = 1'b1; req_write = 1'b1; rs = 8'h10; rt = 8'hA5;
      exp_q.push_back(8'h5C);
      next_cycle();
      req_valid = 1'b0; rs = 8'hFF; rt = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         mem_write_ready = (i == 3);
         sample();
         check("str_wr_valid", mem_write_valid, 1);
         check("str_wr_addr", mem_write_address, 8'h10);
         check("str_wr_data", mem_write_data, 8'hA5);
         check("str_no_done", lsu_done, 0);
         next_cycle();
      end
      mem_write_ready = 1'b0;
      sample();
      check("str_done", lsu_done, 1);
      check("str_out_held", lsu_out, 8'h5C);
      next_cycle();

      // enable low in IDLE
      enable = 1'b0; req_valid = 1'b1; req_write = 1'b0; rs = 8'h01;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("dis_req_ready", req_ready, 0);
         check("dis_mem_valids", {mem_read_valid, mem_write_valid}, 0);
         check("dis_busy", busy, 0);
         next_cycle();
      end
      req_valid = 1'b0;

      // enable drops during a load
      enable = 1'b1; req_valid = 1'b1; req_write = 1'b0; rs = 8'h33;
      exp_q.push_back(8'h77);
      next_cycle();
      req_valid = 1'b0; enable = 1'b0;
      sample();
      check("endrop_rd_valid", mem_read_valid, 1);
      check("endrop_rd_addr", mem_read_address, 8'h33);
      next_cycle();
      next_cycle();
      mem_read_ready = 1'b1; mem_read_data = 8'h77;
      sample();
      check("endrop_still_rd", mem_read_valid, 1);
      next_cycle();
      mem_read_ready = 1'b0;
      sample();
      check("endrop_done", lsu_done, 1);
      check("endrop_out", lsu_out, 8'h77);
      next_cycle();

      // Reset during a write
      enable = 1'b1; req_valid = 1'b1; req_write = 1'b1; rs = 8'h44; rt = 8'h99;
      next_cycle();
      req_valid = 1'b0;
      #1;
      check("rstw_wr_valid_before", mem_write_valid, 1);
      reset = 1'b0;
      #1;
      check("rstw_wr_valid_async", mem_write_valid, 0);
      sample();
      check("rstw_lsu_out", lsu_out, 0);
      check("rstw_req_ready", req_ready, 0);
      check("rstw_wr_addr", mem_write_address, 0);
      next_cycle();
      reset = 1'b1;
      sample();
      check("rstw_idle", busy, 0);
      check("rstw_req_ready_after", req_ready, 1);
      check("rstw_no_done", lsu_done, 0);
      next_cycle();

      // Back-to-back LDR then STR with req_valid held high
      mem_read_ready = 1'b1; mem_read_data = 8'hC3; mem_write_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; rs = 8'h05; rt = 8'h00;
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'hC3);
      next_cycle();
      req_write = 1'b1; rs = 8'h06; rt = 8'h3C;
      sample();
      check("b2b_rd_valid", mem_read_valid, 1);
      check("b2b_rd_addr", mem_read_address, 8'h05);
      check("b2b_busy_ready", req_ready, 0);
      next_cycle();
      sample();
      check("b2b_done1", lsu_done, 1);
      check("b2b_done_ready", req_ready, 0);
      next_cycle();
      sample();
      check("b2b_idle_ready", req_ready, 1);
      next_cycle();
      req_valid = 1'b0;
      sample();
      check("b2b_wr_valid", mem_write_valid, 1);
      check("b2b_wr_addr", mem_write_address, 8'h06);
      check("b2b_wr_data", mem_write_data, 8'h3C);
      next_cycle();
      sample();
      check("b2b_done2", lsu_done, 1);
      check("b2b_out_held", lsu_out, 8'hC3);
      next_cycle();
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("b2b_no_dup", {busy, lsu_done}, 0);
         next_cycle();
      end

      check("sb_drained", exp_q.size(), 0);
      check("sb_done_count", n_done, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
